// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed, little-endian byte image into
// instruction memory and holds the core in reset until the image is fully written.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN. When defined, a trailing XOR
// checksum byte is checked after the last word.
module imem_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              iwr_en_o,
    output logic [ADDR_W-1:0] iaddr_o,
    output logic [31:0]       idata_o,
    output logic              core_rst_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        StLenLo,
        StLenHi,
        StData,
        StWrite,
        StChk,
        StDone,
        StErr
    } state_e;

    // Largest legal word count: a full-depth image.
    localparam logic [16:0] MaxWords = 17'(1) << ADDR_W;

    state_e              state_q, state_d;
    logic [15:0]         len_q;
    logic [16:0]         cnt_q;
    logic [1:0]          bcnt_q;
    logic [23:0]         word_q;
    logic [ADDR_W-1:0]   iaddr_q;
    logic [31:0]         idata_q;
    logic                ready_st;
    logic                accept;
    logic [15:0]         len_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          chk_q;
`endif

    // Length as it becomes complete on the LEN_HI byte.
    assign len_full     = {byte_i, len_q[7:0]};
    // Hold ready low while reset is applied so the port shows its reset value.
    assign byte_ready_o = ready_st && !rst_i;
    assign accept       = byte_valid_i && byte_ready_o;
    assign iaddr_o      = iaddr_q;
    assign idata_o      = idata_q;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StLenLo;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_d    = state_q;
        ready_st   = 1'b0;
        iwr_en_o   = 1'b0;
        core_rst_o = 1'b1;
        done_o     = 1'b0;
        err_o      = 1'b0;
        unique case (state_q)
            StLenLo: begin
                ready_st = 1'b1;
                if (accept) state_d = StLenHi;
            end
            StLenHi: begin
                ready_st = 1'b1;
                if (accept) begin
                    if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = StChk;
`else
                        state_d = StDone;
`endif
                    end else if ({1'b0, len_full} > MaxWords) begin
                        state_d = StErr;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                ready_st = 1'b1;
                if (accept && bcnt_q == 2'd3) state_d = StWrite;
            end
            StWrite: begin
                iwr_en_o = 1'b1;
                if (cnt_q + 17'd1 == {1'b0, len_q}) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = StChk;
`else
                    state_d = StDone;
`endif
                end else begin
                    state_d = StData;
                end
            end
            StChk: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                ready_st = 1'b1;
                if (accept) state_d = (byte_i == chk_q) ? StDone : StErr;
`else
                state_d = StErr;
`endif
            end
            StDone: begin
                core_rst_o = 1'b0;
                done_o     = 1'b1;
            end
            StErr: begin
                err_o = 1'b1;
            end
            default: state_d = StErr;
        endcase
    end

    // Datapath: length capture, word assembly, write-port registers, word count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_q   <= '0;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            iaddr_q <= '0;
            idata_q <= '0;
        end else begin
            if (state_q == StLenLo && accept) len_q[7:0]  <= byte_i;
            if (state_q == StLenHi && accept) len_q[15:8] <= byte_i;
            if (state_q == StData && accept) begin
                bcnt_q <= bcnt_q + 2'd1;
                word_q <= {byte_i, word_q[23:8]};
                if (bcnt_q == 2'd3) begin
                    // Word count doubles as the word address; it never exceeds depth-1 here.
                    idata_q <= {byte_i, word_q};
                    iaddr_q <= cnt_q[ADDR_W-1:0];
                end
            end
            if (state_q == StWrite) cnt_q <= cnt_q + 17'd1;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over data bytes only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chk_q <= '0;
        end else if (state_q == StData && accept) begin
            chk_q <= chk_q ^ byte_i;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W = 8). Honours IMEM_LOADER_CHECKSUM_EN
// by appending the checksum byte where the image needs one.
module tb_imem_loader;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        iwr_en_o;
    logic [7:0]  iaddr_o;
    logic [31:0] idata_o;
    logic        core_rst_o;
    logic        done_o;
    logic        err_o;

    int n_cmp = 0;
    int n_err = 0;

    // Write monitor state.
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          cyc = 0;
    int          acc_cnt = 0;
    int          lat_bad = 0;
    logic        prev_acc = 1'b0;

    logic [31:0] t2_words [3] = '{32'h00100093, 32'h00200113, 32'h002081B3};

    imem_loader #(.ADDR_W(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .iwr_en_o     (iwr_en_o),
        .iaddr_o      (iaddr_o),
        .idata_o      (idata_o),
        .core_rst_o   (core_rst_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Record every write mid-cycle; a write must follow a 4th data byte by exactly one cycle.
    always @(negedge clk_i) begin
        if (iwr_en_o) begin
            wr_addr.push_back(32'(iaddr_o));
            wr_data.push_back(idata_o);
            wr_cyc.push_back(cyc);
            if (!prev_acc || acc_cnt < 6 || ((acc_cnt - 2) % 4) != 0) lat_bad++;
        end
        prev_acc = byte_valid_i && byte_ready_o;
        if (prev_acc) acc_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        byte_valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    // Present a byte and return 2 time units after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        logic r;
        int   n;
        n = 0;
        r = 1'b0;
        byte_i       = b;
        byte_valid_i = 1'b1;
        do begin
            @(negedge clk_i);
            r = byte_ready_o;
            @(posedge clk_i);
            #2;
            n++;
        end while (!r && n < 40);
        if (!r) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            if (gap > 0) idle($urandom_range(0, gap));
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic send_trailer(input logic [7:0] b);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(b);
`else
        if (b === 8'hxx) byte_i = b;
`endif
    endtask

    task automatic do_reset(input string tag);
        rst_i        = 1'b1;
        byte_valid_i = 1'b0;
        byte_i       = 8'h00;
        @(posedge clk_i);
        #2;
        check({tag, "_rdy"},  32'(byte_ready_o), 32'd0);
        check({tag, "_wr"},   32'(iwr_en_o),     32'd0);
        check({tag, "_addr"}, 32'(iaddr_o),      32'd0);
        check({tag, "_data"}, idata_o,           32'd0);
        check({tag, "_crst"}, 32'(core_rst_o),   32'd1);
        check({tag, "_done"}, 32'(done_o),       32'd0);
        check({tag, "_err"},  32'(err_o),        32'd0);
        rst_i = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        acc_cnt  = 0;
        lat_bad  = 0;
        prev_acc = 1'b0;
    endtask

    task automatic check_t2(input string tag);
        check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd3);
        for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr[i], 32'(i));
            check($sformatf("%s_data%0d", tag, i), wr_data[i], t2_words[i]);
        end
        check({tag, "_lat"},  32'(lat_bad), 32'd0);
        check({tag, "_done"}, 32'(done_o),  32'd1);
        check({tag, "_crst"}, 32'(core_rst_o), 32'd0);
    endtask

    initial begin
        rst_i        = 1'b1;
        byte_valid_i = 1'b0;
        byte_i       = 8'h00;

        // T1: single word image.
        do_reset("t1_rst");
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(32'h00000513, 0);
        check("t1_wr",   32'(iwr_en_o), 32'd1);
        check("t1_addr", 32'(iaddr_o),  32'd0);
        check("t1_data", idata_o,       32'h00000513);
        check("t1_rdy_in_write", 32'(byte_ready_o), 32'd0);
        idle(1);
        send_trailer(8'h16);
        check("t1_done", 32'(done_o),     32'd1);
        check("t1_crst", 32'(core_rst_o), 32'd0);
        check("t1_wr_held_addr", 32'(iaddr_o), 32'd0);
        check("t1_wr_held_data", idata_o, 32'h00000513);
        check("t1_nwr",  32'(wr_addr.size()), 32'd1);

        // T2: three words, valid held high.
        do_reset("t2_rst");
        send_byte(8'h03);
        send_byte(8'h00);
        for (int i = 0; i < 3; i++) send_word(t2_words[i], 0);
        idle(2);
        send_trailer(8'hA3);
        check_t2("t2");
        if (wr_cyc.size() == 3) begin
            check("t2_gap0", 32'(wr_cyc[1] - wr_cyc[0]), 32'd5);
            check("t2_gap1", 32'(wr_cyc[2] - wr_cyc[1]), 32'd5);
        end

        // T3: empty image, then oversize length.
        do_reset("t3_rst");
        send_byte(8'h00);
        send_byte(8'h00);
        send_trailer(8'h00);
        check("t3_empty_done", 32'(done_o), 32'd1);
        check("t3_empty_nwr",  32'(wr_addr.size()), 32'd0);
        do_reset("t3_rst2");
        send_byte(8'h01);
        send_byte(8'h01);
        idle(1);
        check("t3_big_err",  32'(err_o),        32'd1);
        check("t3_big_crst", 32'(core_rst_o),   32'd1);
        check("t3_big_rdy",  32'(byte_ready_o), 32'd0);
        check("t3_big_done", 32'(done_o),       32'd0);

        // T4: T2 image with random idle gaps between bytes.
        do_reset("t4_rst");
        send_byte(8'h03);
        idle($urandom_range(0, 3));
        send_byte(8'h00);
        for (int i = 0; i < 3; i++) send_word(t2_words[i], 3);
        idle(2);
        send_trailer(8'hA3);
        check_t2("t4");

        // T5: reset after two of three words, then reload one word.
        do_reset("t5_rst");
        send_byte(8'h03);
        send_byte(8'h00);
        send_word(t2_words[0], 0);
        send_word(t2_words[1], 0);
        idle(2);
        check("t5_nwr_pre", 32'(wr_addr.size()), 32'd2);
        do_reset("t5_mid");
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(32'hDEADBEEF, 0);
        idle(2);
        send_trailer(8'h22);
        check("t5_nwr",  32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() > 0) begin
            check("t5_addr", wr_addr[0], 32'd0);
            check("t5_data", wr_data[0], 32'hDEADBEEF);
        end
        check("t5_done", 32'(done_o), 32'd1);

        // Full-depth image: LEN = 256, word i carries value i.
        do_reset("full_rst");
        send_byte(8'h00);
        send_byte(8'h01);
        for (int i = 0; i < 256; i++) send_word(32'(i), 0);
        idle(2);
        send_trailer(8'h00);
        check("full_nwr",  32'(wr_addr.size()), 32'd256);
        if (wr_addr.size() == 256) begin
            check("full_last_addr", wr_addr[255], 32'd255);
            check("full_last_data", wr_data[255], 32'd255);
            check("full_mid_data",  wr_data[100], 32'd100);
        end
        check("full_lat",  32'(lat_bad), 32'd0);
        check("full_done", 32'(done_o), 32'd1);
        check("full_err",  32'(err_o),  32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // T6: wrong checksum after the T1 image.
        do_reset("t6_rst");
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(32'h00000513, 0);
        idle(1);
        send_byte(8'h17);
        check("t6_err",  32'(err_o),      32'd1);
        check("t6_crst", 32'(core_rst_o), 32'd1);
        check("t6_done", 32'(done_o),     32'd0);
        check("t6_nwr",  32'(wr_addr.size()), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
